// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready register pipeline with bubble
// collapsing, synchronous flush, registered occupancy count and per-stage taps.
// Optional feature macro: ELASTIC_PIPE_SKID_EN adds a 2-entry skid buffer in
// front of stage 0 so that ready_out is a register (no path from ready_in).
module elastic_pipeline #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 3)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic             flush_in,
  output logic [CNT_W-1:0] count_out,
  output logic [WIDTH-1:0] stage_data_out [DEPTH-1:0],
  output logic [DEPTH-1:0] stage_valid_out
);

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv_s;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] src_data_s;
  logic             src_valid_s;
  logic [CNT_W-1:0] skid_occ_s;

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv_s = '0;
    adv_s[DEPTH-1] = !valid_q[DEPTH-1] || ready_in;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_s[i] = !valid_q[i] || adv_s[i+1];
    end
  end

`ifdef ELASTIC_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q [2];
  logic [WIDTH-1:0] skid_data_d [2];
  logic [1:0]       skid_cnt_q;
  logic [1:0]       skid_cnt_d;
  logic             ready_q;
  logic             ready_d;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;

  // A flush always takes (and drops) the offered beat.
  assign ready_out  = ready_q || flush_in;
  assign skid_occ_s = CNT_W'(skid_cnt_d);

  // Skid buffer: its head feeds stage 0 first; the input bypasses it only when empty.
  always_comb begin
    accept_s    = valid_in && ready_out;
    skid_data_d = skid_data_q;
    skid_cnt_d  = skid_cnt_q;
    pop_s       = adv_s[0] && (skid_cnt_q != 2'd0);
    push_s      = accept_s && !((skid_cnt_q == 2'd0) && adv_s[0]);
    if (skid_cnt_q != 2'd0) begin
      src_data_s  = skid_data_q[0];
      src_valid_s = 1'b1;
    end else begin
      src_data_s  = data_in;
      src_valid_s = accept_s;
    end
    if (pop_s) begin
      skid_data_d[0] = skid_data_q[1];
      skid_cnt_d     = skid_cnt_q - 2'd1;
    end else begin
      skid_cnt_d     = skid_cnt_q;
    end
    if (push_s && (skid_cnt_d != 2'd2)) begin
      skid_data_d[skid_cnt_d[0]] = data_in;
      skid_cnt_d                 = skid_cnt_d + 2'd1;
    end else begin
      skid_cnt_d                 = skid_cnt_d;
    end
    if (flush_in) begin
      skid_cnt_d = 2'd0;
    end else begin
      skid_cnt_d = skid_cnt_d;
    end
    ready_d = (skid_cnt_d != 2'd2);
  end

  // Skid storage and the registered ready (low while in reset).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_cnt_q     <= 2'd0;
      ready_q        <= 1'b0;
    end else begin
      skid_data_q    <= skid_data_d;
      skid_cnt_q     <= skid_cnt_d;
      ready_q        <= ready_d;
    end
  end
`else
  // Without a skid buffer ready propagates combinationally from ready_in.
  assign ready_out   = adv_s[0] || flush_in;
  assign src_data_s  = data_in;
  assign src_valid_s = valid_in && ready_out;
  assign skid_occ_s  = '0;
`endif

  // Stage next state: shift on advance, hold otherwise; flush drops valid bits only.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = DEPTH - 1; i > 0; i--) begin
      if (adv_s[i]) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end else begin
        data_d[i]  = data_q[i];
        valid_d[i] = valid_q[i];
      end
    end
    if (adv_s[0]) begin
      data_d[0]  = src_data_s;
      valid_d[0] = src_valid_s;
    end else begin
      data_d[0]  = data_q[0];
      valid_d[0] = valid_q[0];
    end
    if (flush_in) begin
      data_d  = data_q;
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end
    count_d = popcount(valid_d) + skid_occ_s;
  end

  // Stage registers and occupancy count, cleared asynchronously by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_out        = data_q[DEPTH-1];
  assign valid_out       = valid_q[DEPTH-1];
  assign count_out       = count_q;
  assign stage_valid_out = valid_q;

  // Per-stage data taps.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_data_out[i] = data_q[i];
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline (DEPTH=4, WIDTH=16).
module tb_elastic_pipeline;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 3);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int CAP = DEPTH + 2;
`else
  localparam int CAP = DEPTH;
`endif

  logic             clk_in;
  logic             rst_in;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic             flush_in;
  logic [CNT_W-1:0] count_out;
  logic [WIDTH-1:0] stage_data_out [DEPTH-1:0];
  logic [DEPTH-1:0] stage_valid_out;

  elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .flush_in(flush_in), .count_out(count_out),
    .stage_data_out(stage_data_out), .stage_valid_out(stage_valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the held beats form a FIFO tagged with their accept edge.
  // The head beat is visible once DEPTH-1 further edges have passed.
  logic [WIDTH-1:0] q_d [$];
  int               q_t [$];
  int               edges = 0;
  logic             ev;
  logic             er;
  logic [WIDTH-1:0] ed;
  int               ec;

  task automatic predict();
    ec = q_d.size();
`ifdef ELASTIC_PIPE_SKID_EN
    ev = valid_out;
    er = ready_out;
`else
    ev = (q_d.size() != 0) && (edges - q_t[0] >= DEPTH);
    er = flush_in || (ec < CAP) || ready_in;
`endif
    ed = (q_d.size() != 0) ? q_d[0] : 'x;
  endtask

  task automatic model_clear();
    q_d.delete();
    q_t.delete();
  endtask

  // Advance one clock: update the model with this cycle's handshakes.
  task automatic tick();
    logic in_x, out_x, fl;
    logic [WIDTH-1:0] din;
    predict();
    in_x  = valid_in && er;
    out_x = ev && ready_in;
    fl    = flush_in;
    din   = data_in;
    @(posedge clk_in);
    if (out_x && q_d.size() != 0) begin
      void'(q_d.pop_front());
      void'(q_t.pop_front());
    end
    if (fl) model_clear();
    else if (in_x) begin
      q_d.push_back(din);
      q_t.push_back(edges);
    end
    edges++;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0; flush_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    n_vec++;
    if (valid_out !== 1'b0 || count_out !== '0 || stage_valid_out !== '0 || data_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b count=%0d stage_valid=%b data=%h, required all zero",
               valid_out, count_out, stage_valid_out, data_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (stage_data_out[i] !== '0) begin
        n_err++;
        $display("FAIL reset_stage_data[%0d]: got %h, required 0", i, stage_data_out[i]);
      end
    end
    n_vec++;
`ifdef ELASTIC_PIPE_SKID_EN
    if (ready_out !== 1'b0) begin
`else
    if (ready_out !== 1'b1) begin
`endif
      n_err++;
      $display("FAIL reset_ready: got %b", ready_out);
    end
    rst_in = 1'b0;
    model_clear();
    edges = 0;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_stream();
    ready_in = 1'b1;
    for (int i = 0; i < 16 + DEPTH + 2; i++) begin
      valid_in = (i < 16);
      data_in  = WIDTH'(i + 1);
      #1;
      if (i >= DEPTH && i < 16 + DEPTH) begin
        n_vec++;
        if (valid_out !== 1'b1 || data_out !== WIDTH'(i - DEPTH + 1)) begin
          n_err++;
          $display("FAIL stream_latency cyc %0d: valid=%b data=%h, required 1/%h",
                   i, valid_out, data_out, WIDTH'(i - DEPTH + 1));
        end
      end
      if (i >= DEPTH && i < 16) begin
        n_vec++;
        if (count_out !== CNT_W'(DEPTH)) begin
          n_err++;
          $display("FAIL stream_count cyc %0d: got %0d, required %0d", i, count_out, DEPTH);
        end
      end
      tick();
    end
  endtask

  task automatic test_fill();
    int k;
    k = 0;
    ready_in = 1'b0;
    for (int c = 0; c < CAP + 2; c++) begin
      valid_in = 1'b1;
      data_in  = WIDTH'(16'h000A + k);
      #1;
      n_vec++;
      if (ready_out !== (k < CAP)) begin
        n_err++;
        $display("FAIL fill_ready after %0d accepts: got %b, required %b", k, ready_out, (k < CAP));
      end
      predict();
      if (er) k++;
      tick();
    end
    valid_in = 1'b0;
    #1;
    n_vec++;
    if (count_out !== CNT_W'(CAP)) begin
      n_err++;
      $display("FAIL fill_count: got %0d, required %0d", count_out, CAP);
    end
    ready_in = 1'b1;
    for (int c = 0; c < CAP + 2; c++) begin
      #1;
      if (c < CAP) begin
        n_vec++;
        if (valid_out !== 1'b1 || data_out !== WIDTH'(16'h000A + c)) begin
          n_err++;
          $display("FAIL fill_order beat %0d: valid=%b data=%h, required 1/%h",
                   c, valid_out, data_out, WIDTH'(16'h000A + c));
        end
      end
      tick();
    end
  endtask

  task automatic test_bubble();
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 16'h0100;
    tick();
    valid_in = 1'b0;
    repeat (DEPTH - 1) tick();
    for (int i = 1; i < DEPTH; i++) begin
      valid_in = 1'b1;
      data_in  = WIDTH'(16'h0100 + i);
      #1;
      n_vec++;
      if (ready_out !== 1'b1) begin
        n_err++;
        $display("FAIL bubble_accept beat %0d: ready=%b, required 1", i, ready_out);
      end
      tick();
    end
    valid_in = 1'b0;
    #1;
    n_vec++;
    if (stage_valid_out !== {DEPTH{1'b1}} || count_out !== CNT_W'(DEPTH)) begin
      n_err++;
      $display("FAIL bubble_full: stage_valid=%b count=%0d, required all ones/%0d",
               stage_valid_out, count_out, DEPTH);
    end
    ready_in = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      #1;
      if (c < DEPTH) begin
        n_vec++;
        if (valid_out !== 1'b1 || data_out !== WIDTH'(16'h0100 + c)) begin
          n_err++;
          $display("FAIL bubble_order beat %0d: valid=%b data=%h", c, valid_out, data_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = WIDTH'(16'h0011 * (i + 1));
      tick();
    end
    valid_in = 1'b1;
    data_in  = 16'h00FF;
    flush_in = 1'b1;
    #1;
    n_vec++;
    if (count_out !== CNT_W'(3) || ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre: count=%0d ready=%b, required 3/1", count_out, ready_out);
    end
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    #1;
    n_vec++;
    if (count_out !== '0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL flush_post: count=%0d valid=%b, required 0/0", count_out, valid_out);
    end
    ready_in = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) begin
      #1;
      n_vec++;
      if (valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL flush_drop cyc %0d: valid=%b data=%h, required no beat", c, valid_out, data_out);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = WIDTH'(16'h0200 + i);
      tick();
    end
    #2 rst_in = 1'b1;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || count_out !== '0 || stage_valid_out !== '0 || data_out !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d stage_valid=%b data=%h, required all zero",
               valid_out, count_out, stage_valid_out, data_out);
    end
    valid_in = 1'b0;
    model_clear();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    for (int i = 0; i < 6 + DEPTH + 2; i++) begin
      valid_in = (i < 6);
      data_in  = WIDTH'(16'h0300 + i);
      #1;
      if (i >= DEPTH && i < DEPTH + 6) begin
        n_vec++;
        if (valid_out !== 1'b1 || data_out !== WIDTH'(16'h0300 + i - DEPTH)) begin
          n_err++;
          $display("FAIL resume_latency cyc %0d: valid=%b data=%h, required 1/%h",
                   i, valid_out, data_out, WIDTH'(16'h0300 + i - DEPTH));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      valid_in = ($urandom_range(3) != 0);
      ready_in = ($urandom_range(2) != 0);
      flush_in = ($urandom_range(96) == 0);
      data_in  = WIDTH'($urandom);
      #1;
      predict();
`ifndef ELASTIC_PIPE_SKID_EN
      n_vec++;
      if (valid_out !== ev || ready_out !== er) begin
        n_err++;
        $display("FAIL rand_handshake cyc %0d: valid=%b ready=%b, required %b/%b",
                 c, valid_out, ready_out, ev, er);
      end
`endif
      if (ev) begin
        n_vec++;
        if (data_out !== ed) begin
          n_err++;
          $display("FAIL rand_data cyc %0d: got %h, required %h", c, data_out, ed);
        end
      end
      n_vec++;
      if (count_out !== CNT_W'(ec)) begin
        n_err++;
        $display("FAIL rand_count cyc %0d: got %0d, required %0d", c, count_out, ec);
      end
      tick();
    end
    valid_in = 1'b0;
    flush_in = 1'b0;
    ready_in = 1'b1;
    repeat (CAP + 3) tick();
    #1;
    n_vec++;
    if (count_out !== '0 || q_d.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: count=%0d model=%0d, required 0", count_out, q_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
